dc_input_buffer: RTL
====================

Name: dc_input_buffer

Overview:
- Receiver-side decoupled input stage; complement to the registered output stage on the same srdy/drdy protocol.
- Accepts words from an upstream producer and buffers up to DEPTH entries.
- Presents buffered words to downstream logic in strict FIFO order.
- Upstream-facing c_drdy is driven purely from registered state, so upstream valid/ready timing paths terminate at this block.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, buffer entries; power of two, minimum 2.
- CW, log2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- c_srdy  input  1  upstream word valid.
- c_drdy  output  1  upstream may transfer; registered.
- c_data  input  WIDTH  upstream word.
- p_srdy  output  1  downstream word valid.
- p_drdy  input  1  downstream accepts.
- p_data  output  WIDTH  head-of-buffer word.
- usage  output  CW  current occupancy, 0..DEPTH.
- ovf_error  output  1  sticky protocol error flag.

Behaviour:
- Reset (reset low at rising edge of clock):
  - rd_ptr = 0, wr_ptr = 0, usage = 0.
  - c_drdy = 0 during reset; 1 on the first cycle after reset releases.
  - p_srdy = 0, ovf_error = 0.
  - p_data is don't-care while p_srdy = 0.
  - Storage is not cleared.
  - A reset asserted mid-operation discards all buffered words immediately at that edge.
- Transfers:
  - Enqueue: c_srdy & c_drdy at a rising edge. c_data is written to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - Dequeue: p_srdy & p_drdy at a rising edge. rd_ptr increments modulo DEPTH.
- Occupancy:
  - usage_next = usage + enq - deq.
  - Simultaneous enq and deq leave usage unchanged. Both pointers still advance.
- Outputs:
  - p_srdy = (usage != 0), registered state only.
  - p_data = mem[rd_ptr].
  - No combinational fall-through: a word enqueued in cycle N is first visible on p_srdy/p_data in cycle N+1.
- c_drdy is a register with next value (usage_next < DEPTH). It is therefore low exactly in the cycle after the buffer reaches full.
- Full (usage == DEPTH):
  - c_drdy = 0; no enqueue regardless of c_srdy.
  - A dequeue in a full cycle raises c_drdy on the next cycle.
- Empty (usage == 0): p_srdy = 0; p_drdy is ignored.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble; ordering is preserved across the wrap.
- ovf_error:
  - Sets if an internal enqueue is ever attempted while usage == DEPTH. This is defence against a corrupted c_drdy.
  - Sticky until reset.
  - In correct operation it never asserts; it is a formal proof target.
- Protocol:
  - Upstream may drop c_srdy or change c_data at any time without a transfer.
  - The block never drops p_srdy or changes p_data until a dequeue occurs.
  - Formal property: once p_srdy is high, p_srdy stays high and p_data stays stable until p_drdy.
- Throughput: one word per cycle sustained when DEPTH >= 2 and downstream holds p_drdy = 1.
- Latency: 1 cycle from accept to p_srdy.

Test Plan:
- Reset then idle, c_srdy = 0 for 5 cycles -> usage = 0, p_srdy = 0, c_drdy = 1 from cycle 1 after reset release, ovf_error = 0.
- Single word 0x1234 with p_drdy = 0:
  - Next cycle: p_srdy = 1, p_data = 0x1234, usage = 1.
  - Held for 10 cycles: p_data stable; assert p_drdy -> p_srdy = 0 the following cycle.
- Fill with p_drdy = 0, DEPTH = 2, words 0xA, 0xB:
  - After the second accept, c_drdy = 0 and usage = 2.
  - A third offer (0xC) is not accepted.
  - Release p_drdy for 3 cycles -> output order 0xA, 0xB, 0xC.
- Streaming with c_srdy = 1 and p_drdy = 1, counting sequence 0..99:
  - 100 words out in order, no gaps after the first, usage settles at 1.
  - Pointers wrap 50 times with no sequence error.
- Random c_srdy/p_drdy (50% each), 10k cycles, sequence-numbered data -> scoreboard matches exactly, usage never > DEPTH, ovf_error = 0.
- Reset asserted with usage = 2 -> next cycle usage = 0, p_srdy = 0. The next word after release (0x55) is the first output; prior contents are never presented.

Source files
------------

// File: rtl/dc_input_buffer.sv
// Receiver-side decoupled input buffer: DEPTH-entry FIFO on the srdy/drdy protocol.
// c_drdy and p_srdy come only from registers, so no combinational path crosses the block.
module dc_input_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [WIDTH-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [WIDTH-1:0] p_data,
  output logic [CW-1:0]    usage,
  output logic             ovf_error
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    usage_next;
  logic             full;
  logic             enq_attempt;
  logic             enq;
  logic             deq;

  assign full        = (usage == CW'(DEPTH));
  assign enq_attempt = c_srdy & c_drdy;
  // The full gate is redundant while c_drdy is healthy; it keeps a corrupted
  // c_drdy from overwriting the head entry.
  assign enq         = enq_attempt & ~full;
  assign deq         = p_srdy & p_drdy;

  always_comb begin
    usage_next = usage;
    case ({enq, deq})
      2'b10:   usage_next = usage + 1'b1;
      2'b01:   usage_next = usage - 1'b1;
      default: usage_next = usage;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      usage     <= '0;
      c_drdy    <= 1'b0;
      p_srdy    <= 1'b0;
      ovf_error <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      usage     <= usage_next;
      c_drdy    <= (usage_next < CW'(DEPTH));
      p_srdy    <= (usage_next != '0);
      if (enq_attempt && full) ovf_error <= 1'b1;
    end
  end

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clock) begin
    if (reset && enq) mem[wr_ptr] <= c_data;
  end

  assign p_data = mem[rd_ptr];

  property p_hold;
    @(posedge clock) disable iff (!reset)
      (p_srdy && !p_drdy) |=> (p_srdy && $stable(p_data));
  endproperty
  a_hold: assert property (p_hold);

  a_no_ovf: assert property (@(posedge clock) disable iff (!reset) !ovf_error);

endmodule
